// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access: MEM pipeline stage of a simple in-order core.
//
// Issues word loads/stores from the MEM stage onto a request/ack data bus
// (addr_ok = request accepted, data_ok = transfer done). While a bus access is
// outstanding it raises stall_o, so upstream holds its outputs. The WB-stage
// register is loaded with the completed instruction, or with a bubble while
// stalled. A misaligned load or store never reaches the bus. It retires as a
// non-writing instruction and pulses addr_err_o for one cycle.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-low reset
//   mem_valid_i            MEM-stage instruction valid
//   mem_wd_i, mem_wreg_i   destination register address / write enable
//   mem_wdata_i            ALU result; effective address for load/store
//   mem_op_i               00 none, 01 load, 10 store, 11 reserved (none)
//   mem_sdata_i            store data
//   data_req_o, data_wr_o  bus request / write strobe
//   data_addr_o            bus address
//   data_wdata_o           bus write data
//   data_addr_ok_i         request accepted
//   data_data_ok_i         transfer complete (read data valid)
//   data_rdata_i           bus read data
//   stall_o                freeze upstream stages
//   wb_*_o                 registered WB-stage signals
//   addr_err_o             registered one-cycle misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          mem_valid_i,
    input  logic [AW-1:0] mem_wd_i,
    input  logic          mem_wreg_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic [1:0]    mem_op_i,
    input  logic [DW-1:0] mem_sdata_i,
    output logic          data_req_o,
    output logic          data_wr_o,
    output logic [DW-1:0] data_addr_o,
    output logic [DW-1:0] data_wdata_o,
    input  logic          data_addr_ok_i,
    input  logic          data_data_ok_i,
    input  logic [DW-1:0] data_rdata_i,
    output logic          stall_o,
    output logic          wb_valid_o,
    output logic [AW-1:0] wb_wd_o,
    output logic          wb_wreg_o,
    output logic [DW-1:0] wb_wdata_o,
    output logic          addr_err_o
);

    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;

    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_wd_q, wb_wd_d;
    logic          wb_wreg_q, wb_wreg_d;
    logic [DW-1:0] wb_wdata_q, wb_wdata_d;
    logic          addr_err_q, addr_err_d;

    logic is_ldst;
    logic is_load;
    logic aligned;
    logic is_access;
    logic is_misaligned;
    logic req;
    logic complete;
    logic stall;

    // Instruction decode
    assign is_load       = (mem_op_i == OpLoad);
    assign is_ldst       = is_load || (mem_op_i == OpStore);
    assign aligned       = (mem_wdata_i[1:0] == 2'b00);
    assign is_access     = mem_valid_i && is_ldst && aligned;
    assign is_misaligned = mem_valid_i && is_ldst && !aligned;

    // Bus FSM: next state, request and completion
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_access) begin
                    req = 1'b1;
                    if (data_addr_ok_i && data_data_ok_i) begin
                        complete = 1'b1;
                    end else if (data_addr_ok_i) begin
                        state_d = StWait;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                // Request held; a lone data_ok here is not a response to us.
                req = 1'b1;
                if (data_addr_ok_i && data_data_ok_i) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else if (data_addr_ok_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (data_data_ok_i) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An access is in progress if a request is pending or outstanding.
    assign stall = ((state_q != StIdle) || is_access) && !complete;

    // Gate with reset so a held access cannot raise a request while in reset.
    assign data_req_o   = req && rst_i;
    assign stall_o      = stall && rst_i;
    assign data_wr_o    = req && (mem_op_i == OpStore);
    assign data_addr_o  = req ? mem_wdata_i : '0;
    assign data_wdata_o = req ? mem_sdata_i : '0;

    // WB register next state
    always_comb begin
        wb_valid_d = 1'b0;
        wb_wd_d    = '0;
        wb_wreg_d  = 1'b0;
        wb_wdata_d = '0;
        addr_err_d = 1'b0;
        if (complete) begin
            wb_valid_d = 1'b1;
            wb_wd_d    = mem_wd_i;
            wb_wreg_d  = is_load ? mem_wreg_i : 1'b0;
            wb_wdata_d = is_load ? data_rdata_i : mem_wdata_i;
        end else if (stall) begin
            // Bubble while waiting on the bus.
        end else if (is_misaligned) begin
            wb_valid_d = 1'b1;
            wb_wd_d    = mem_wd_i;
            wb_wdata_d = mem_wdata_i;
            addr_err_d = 1'b1;
        end else if (mem_valid_i) begin
            // Non-memory op passes straight through.
            wb_valid_d = 1'b1;
            wb_wd_d    = mem_wd_i;
            wb_wreg_d  = mem_wreg_i;
            wb_wdata_d = mem_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            wb_valid_q <= 1'b0;
            wb_wd_q    <= '0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_wd_o    = wb_wd_q;
    assign wb_wreg_o  = wb_wreg_q;
    assign wb_wdata_o = wb_wdata_q;
    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access: directed self-checking bench for mem_access.
// Inputs change 1ns after a rising edge. Combinational outputs are sampled
// 1ns later. Registered outputs are sampled 1ns after the next rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_valid;
    logic [AW-1:0] mem_wd;
    logic          mem_wreg;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_op;
    logic [DW-1:0] mem_sdata;
    logic          data_req;
    logic          data_wr;
    logic [DW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;
    logic          stall;
    logic          wb_valid;
    logic [AW-1:0] wb_wd;
    logic          wb_wreg;
    logic [DW-1:0] wb_wdata;
    logic          addr_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access #(.DW(DW), .AW(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .mem_valid_i    (mem_valid),
        .mem_wd_i       (mem_wd),
        .mem_wreg_i     (mem_wreg),
        .mem_wdata_i    (mem_wdata),
        .mem_op_i       (mem_op),
        .mem_sdata_i    (mem_sdata),
        .data_req_o     (data_req),
        .data_wr_o      (data_wr),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_addr_ok_i (addr_ok),
        .data_data_ok_i (data_ok),
        .data_rdata_i   (rdata),
        .stall_o        (stall),
        .wb_valid_o     (wb_valid),
        .wb_wd_o        (wb_wd),
        .wb_wreg_o      (wb_wreg),
        .wb_wdata_o     (wb_wdata),
        .addr_err_o     (addr_err)
    );

    task automatic drive_idle();
        mem_valid = 1'b0;
        mem_wd    = '0;
        mem_wreg  = 1'b0;
        mem_wdata = '0;
        mem_op    = 2'b00;
        mem_sdata = '0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = '0;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        tests++;
        if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        tests++;
        if (wb_wdata !== 32'h0) begin fails++; $display("FAIL reset_wb_wdata got %h want 0", wb_wdata); end
        tests++;
        if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
        tests++;
        if (data_req !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL reset_bus got req=%b stall=%b want 0 0", data_req, stall);
        end
        next_edge();
        next_edge();
        rst_n = 1'b1;
        next_edge();
    endtask

    task automatic test_alu();
        mem_valid = 1'b1; mem_op = 2'b00; mem_wd = 5'd5; mem_wreg = 1'b1;
        mem_wdata = 32'h1234;
        #1;
        tests++;
        if (stall !== 1'b0 || data_req !== 1'b0) begin
            fails++; $display("FAIL alu_bus got stall=%b req=%b want 0 0", stall, data_req);
        end
        next_edge();
        tests++;
        if (wb_valid !== 1'b1 || wb_wd !== 5'd5 || wb_wreg !== 1'b1 || wb_wdata !== 32'h1234) begin
            fails++;
            $display("FAIL alu_wb got v=%b wd=%0d wr=%b d=%h want 1 5 1 00001234",
                     wb_valid, wb_wd, wb_wreg, wb_wdata);
        end
        // Reserved op 11 behaves as a non-memory op.
        mem_op = 2'b11; mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h0000_0102;
        #1;
        tests++;
        if (data_req !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL rsvd_bus got req=%b stall=%b want 0 0", data_req, stall);
        end
        next_edge();
        tests++;
        if (wb_valid !== 1'b1 || wb_wd !== 5'd9 || wb_wreg !== 1'b1 || wb_wdata !== 32'h102 ||
            addr_err !== 1'b0) begin
            fails++;
            $display("FAIL rsvd_wb got v=%b wd=%0d wr=%b d=%h err=%b want 1 9 1 00000102 0",
                     wb_valid, wb_wd, wb_wreg, wb_wdata, addr_err);
        end
        drive_idle();
        next_edge();
        tests++;
        if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_wdata !== 32'h0) begin
            fails++; $display("FAIL idle_bubble got v=%b wr=%b d=%h want 0 0 0", wb_valid, wb_wreg, wb_wdata);
        end
    endtask

    // Load at 0x100: addr_ok at cycle 2, data_ok at cycle 6 (and a stray data_ok at
    // cycle 1 in REQ, which must be ignored). Request cycles 0..2, stall cycles 0..5.
    task automatic test_load_delayed();
        int req_cnt = 0;
        int stall_cnt = 0;
        bit done = 0;
        mem_valid = 1'b1; mem_op = 2'b01; mem_wd = 5'd3; mem_wreg = 1'b1;
        mem_wdata = 32'h100;
        for (int c = 0; c < 20 && !done; c++) begin
            addr_ok = (c == 2);
            data_ok = (c == 1) || (c == 6);
            rdata   = (c == 6) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (data_req) begin
                req_cnt++;
                tests++;
                if (data_addr !== 32'h100 || data_wr !== 1'b0) begin
                    fails++; $display("FAIL load_bus c=%0d got addr=%h wr=%b want 00000100 0", c, data_addr, data_wr);
                end
            end
            if (stall) stall_cnt++;
            next_edge();
            if (c == 6) begin
                done = 1;
            end else if (wb_valid !== 1'b0) begin
                tests++; fails++;
                $display("FAIL load_bubble c=%0d got v=%b want 0", c, wb_valid);
            end
        end
        tests++;
        if (!done) begin fails++; $display("FAIL load_timeout got no completion want completion"); end
        tests++;
        if (req_cnt != 3) begin fails++; $display("FAIL load_req_cycles got %0d want 3", req_cnt); end
        tests++;
        if (stall_cnt != 6) begin fails++; $display("FAIL load_stall_cycles got %0d want 6", stall_cnt); end
        tests++;
        if (wb_valid !== 1'b1 || wb_wd !== 5'd3 || wb_wreg !== 1'b1 || wb_wdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL load_wb got v=%b wd=%0d wr=%b d=%h want 1 3 1 deadbeef",
                     wb_valid, wb_wd, wb_wreg, wb_wdata);
        end
        drive_idle();
        next_edge();
    endtask

    task automatic test_store();
        mem_valid = 1'b1; mem_op = 2'b10; mem_wd = 5'd4; mem_wreg = 1'b1;
        mem_wdata = 32'h200; mem_sdata = 32'hA5A5_A5A5; addr_ok = 1'b1; data_ok = 1'b1;
        #1;
        tests++;
        if (data_req !== 1'b1 || data_wr !== 1'b1 || data_addr !== 32'h200 ||
            data_wdata !== 32'hA5A5_A5A5 || stall !== 1'b0) begin
            fails++;
            $display("FAIL store_bus got req=%b wr=%b a=%h d=%h stall=%b want 1 1 00000200 a5a5a5a5 0",
                     data_req, data_wr, data_addr, data_wdata, stall);
        end
        next_edge();
        tests++;
        if (wb_valid !== 1'b1 || wb_wreg !== 1'b0 || wb_wd !== 5'd4 || wb_wdata !== 32'h200) begin
            fails++;
            $display("FAIL store_wb got v=%b wr=%b wd=%0d d=%h want 1 0 4 00000200",
                     wb_valid, wb_wreg, wb_wd, wb_wdata);
        end
        drive_idle();
        next_edge();
    endtask

    task automatic test_misaligned();
        mem_valid = 1'b1; mem_op = 2'b01; mem_wd = 5'd6; mem_wreg = 1'b1;
        mem_wdata = 32'h102; addr_ok = 1'b1; data_ok = 1'b1;
        #1;
        tests++;
        if (data_req !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL misal_bus got req=%b stall=%b want 0 0", data_req, stall);
        end
        next_edge();
        tests++;
        if (addr_err !== 1'b1 || wb_valid !== 1'b1 || wb_wreg !== 1'b0) begin
            fails++;
            $display("FAIL misal_wb got err=%b v=%b wr=%b want 1 1 0", addr_err, wb_valid, wb_wreg);
        end
        drive_idle();
        next_edge();
        tests++;
        if (addr_err !== 1'b0) begin fails++; $display("FAIL misal_pulse got err=%b want 0", addr_err); end
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1; mem_op = 2'b01; mem_wd = 5'd7; mem_wreg = 1'b1;
        mem_wdata = 32'h300; addr_ok = 1'b1;
        next_edge();
        addr_ok = 1'b0;
        #1;
        tests++;
        if (data_req !== 1'b0 || stall !== 1'b1) begin
            fails++; $display("FAIL wait_state got req=%b stall=%b want 0 1", data_req, stall);
        end
        // Assert reset with the access still presented.
        rst_n = 1'b0;
        #1;
        tests++;
        if (data_req !== 1'b0 || wb_valid !== 1'b0 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got req=%b v=%b err=%b want 0 0 0", data_req, wb_valid, addr_err);
        end
        next_edge();
        drive_idle();
        rst_n = 1'b1;
        next_edge();
        data_ok = 1'b1;
        rdata = 32'hBAD0_BAD0;
        #1;
        tests++;
        if (stall !== 1'b0 || data_req !== 1'b0) begin
            fails++; $display("FAIL late_ack_bus got stall=%b req=%b want 0 0", stall, data_req);
        end
        next_edge();
        tests++;
        if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_wdata !== 32'h0) begin
            fails++;
            $display("FAIL late_ack_wb got v=%b wr=%b d=%h want 0 0 0", wb_valid, wb_wreg, wb_wdata);
        end
        drive_idle();
        next_edge();
    endtask

    task automatic test_back_to_back();
        mem_valid = 1'b1; mem_op = 2'b01; mem_wd = 5'd10; mem_wreg = 1'b1;
        mem_wdata = 32'h10; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1111_1111;
        #1;
        tests++;
        if (data_req !== 1'b1 || data_wr !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL b2b_ld_bus got req=%b wr=%b stall=%b want 1 0 0", data_req, data_wr, stall);
        end
        next_edge();
        tests++;
        if (wb_valid !== 1'b1 || wb_wd !== 5'd10 || wb_wreg !== 1'b1 || wb_wdata !== 32'h1111_1111) begin
            fails++;
            $display("FAIL b2b_ld_wb got v=%b wd=%0d wr=%b d=%h want 1 10 1 11111111",
                     wb_valid, wb_wd, wb_wreg, wb_wdata);
        end
        mem_op = 2'b10; mem_wd = 5'd11; mem_wdata = 32'h20; mem_sdata = 32'h2222_2222;
        rdata = 32'h0;
        #1;
        tests++;
        if (data_req !== 1'b1 || data_wr !== 1'b1 || data_addr !== 32'h20 ||
            data_wdata !== 32'h2222_2222) begin
            fails++;
            $display("FAIL b2b_st_bus got req=%b wr=%b a=%h d=%h want 1 1 00000020 22222222",
                     data_req, data_wr, data_addr, data_wdata);
        end
        next_edge();
        tests++;
        if (wb_valid !== 1'b1 || wb_wd !== 5'd11 || wb_wreg !== 1'b0 || wb_wdata !== 32'h20) begin
            fails++;
            $display("FAIL b2b_st_wb got v=%b wd=%0d wr=%b d=%h want 1 11 0 00000020",
                     wb_valid, wb_wd, wb_wreg, wb_wdata);
        end
        drive_idle();
        next_edge();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_alu();
        test_load_delayed();
        test_store();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
